ads1256_sample_assembler: RTL and testbench
===========================================

ADS1256_SAMPLE_ASSEMBLER -- requirements
Module: ads1256_sample_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 SHALL have port clock_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port frame_start_i  input  1  one-cycle pulse marking the start of an RDATA read phase.
REQ-005 SHALL have port channel_i  input  4  mux channel tag, sampled on frame_start_i.
REQ-006 SHALL have port byte_valid_i  input  1  one-cycle pulse from the SPI master done strobe.
REQ-007 SHALL have port byte_i  input  8  received SPI byte, valid with byte_valid_i.
REQ-008 SHALL have port sample_valid_o  output  1  FIFO head holds a sample.
REQ-009 SHALL have port sample_ready_i  input  1  consumer accepts the head when high with sample_valid_o.
REQ-010 SHALL have port sample_data_o  output  32  head sample, 24-bit code sign-extended.
REQ-011 SHALL have port sample_channel_o  output  4  head sample channel tag.
REQ-012 SHALL have port fifo_count_o  output  $clog2(DEPTH)+1  occupied entries.
REQ-013 SHALL have port overflow_o  output  1  sticky, set when a completed sample is dropped.
REQ-014 SHALL have port clear_overflow_i  input  1  synchronous clear of overflow_o.

Function
REQ-015 SHALL run an FSM with states IDLE, MSB, MID, LSB.
- IDLE -> MSB on frame_start_i; latch channel_i.
- MSB -> MID, MID -> LSB on byte_valid_i.
- LSB -> IDLE on byte_valid_i.
REQ-016 SHALL shift bytes MSB first: first byte = bits 23:16, second = 15:8, third = 7:0.
REQ-017 SHALL ignore byte_valid_i in IDLE.
REQ-018 SHALL give frame_start_i priority over a coincident byte_valid_i; the byte is discarded and the FSM enters MSB.
REQ-019 SHALL, on frame_start_i in MSB, MID or LSB, discard the partial sample silently (overflow_o unchanged) and restart in MSB.
REQ-020 SHALL form the word as {8 copies of bit 23, 24-bit code}; 0x800000 -> 0xFF800000, 0x7FFFFF -> 0x007FFFFF.
REQ-021 SHALL push {channel, word} into the FIFO on the clock edge that samples the third byte_valid_i.
REQ-022 SHALL present a first-word-fall-through head, so sample_valid_o rises the cycle after a push into an empty FIFO.
REQ-023 SHALL pop on the edge where sample_valid_o and sample_ready_i are both high.
REQ-024 SHALL accept a push when full if a pop occurs on the same edge; fifo_count_o is then unchanged.
REQ-025 SHALL drop a push when full with no pop, set overflow_o, and leave FIFO contents unchanged.
REQ-026 SHALL, on simultaneous push and pop with count 1, keep count at 1 with the new sample at the head.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL give a coincident overflow set priority over clear_overflow_i.
REQ-029 SHALL hold sample_data_o and sample_channel_o stable while sample_valid_o is high and sample_ready_i is low.

Reset
REQ-030 SHALL, on reset_i low, immediately force FSM=IDLE, pointers=0, fifo_count_o=0, sample_valid_o=0, overflow_o=0, sample_data_o=0, sample_channel_o=0.
REQ-031 SHALL discard any partial frame and all stored samples on reset mid-operation.
REQ-032 SHALL need a fresh frame_start_i after reset deassertion before any byte is captured.

Configuration
REQ-033 SHALL, with ADS1256_SAMPLE_TIMESTAMP_EN defined:
- keep a 32-bit free-running cycle counter, reset to 0 and wrapping at 2^32;
- capture the counter on frame_start_i and store it per FIFO entry;
- expose it on output port sample_timestamp_o (32 bits), aligned with the head sample.
REQ-034 SHALL, without ADS1256_SAMPLE_TIMESTAMP_EN, omit the counter, the timestamp storage and the sample_timestamp_o port.

Verification
REQ-035 Frame: frame_start, ch=3, bytes 0x12,0x34,0x56, ready=1 -> one sample 0x00123456, ch 3, then count 0.
REQ-036 Sign: bytes 0x80,0x00,0x01 -> sample_data_o=0xFF800001.
REQ-037 Abort: frame_start, bytes 0xAA,0xBB, then frame_start, bytes 0x01,0x02,0x03 -> single sample 0x00010203, overflow_o=0.
REQ-038 Full: ready=0, DEPTH+1 frames -> fifo_count_o=DEPTH, overflow_o=1, head = first sample; then clear_overflow_i -> overflow_o=0.
REQ-039 Reset: assert reset_i low after the second byte of a frame with 3 samples queued -> count 0, sample_valid_o=0 immediately; bytes without frame_start ignored.
REQ-040 Timestamp (macro defined): frame_start at counter 100 -> sample_timestamp_o=100 with that sample.

Source files
------------

// File: rtl/ads1256_sample_assembler.sv
// ads1256_sample_assembler: packs three RDATA bytes into sign-extended samples queued in an FWFT FIFO.
// Optional ADS1256_SAMPLE_TIMESTAMP_EN adds a per-sample 32-bit cycle timestamp (sample_timestamp_o).
`default_nettype none

module ads1256_sample_assembler #(
  parameter int DEPTH = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     frame_start_i,
  input  logic [3:0]               channel_i,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_i,
  output logic                     sample_valid_o,
  input  logic                     sample_ready_i,
  output logic [31:0]              sample_data_o,
  output logic [3:0]               sample_channel_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o,
`ifdef ADS1256_SAMPLE_TIMESTAMP_EN
  output logic [31:0]              sample_timestamp_o,
`endif
  input  logic                     clear_overflow_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
`ifdef ADS1256_SAMPLE_TIMESTAMP_EN
  localparam int ENTRY_W = 68;
`else
  localparam int ENTRY_W = 36;
`endif

  typedef enum logic [1:0] {IDLE, MSB, MID, LSB} state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        frame_channel;
  logic [7:0]        byte_hi;
  logic [7:0]        byte_mid;
  logic [23:0]       code;
  logic [31:0]       word;
  logic              push;
  logic              pop;
  logic              full;
  logic              write_en;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= next_state;
  end

  // A frame start always restarts the byte sequence, even mid-frame.
  always_comb begin
    next_state = state;
    if (frame_start_i) begin
      next_state = MSB;
    end else if (byte_valid_i) begin
      case (state)
        MSB:     next_state = MID;
        MID:     next_state = LSB;
        LSB:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      frame_channel <= '0;
      byte_hi       <= '0;
      byte_mid      <= '0;
    end else if (frame_start_i) begin
      frame_channel <= channel_i;
    end else if (byte_valid_i) begin
      if (state == MSB) byte_hi  <= byte_i;
      if (state == MID) byte_mid <= byte_i;
    end
  end

  assign code     = {byte_hi, byte_mid, byte_i};
  assign word     = {{8{code[23]}}, code};
  assign push     = (state == LSB) && byte_valid_i && !frame_start_i;
  assign pop      = sample_valid_o && sample_ready_i;
  assign full     = (count == FULL_COUNT);
  assign write_en = push && (!full || pop);

`ifdef ADS1256_SAMPLE_TIMESTAMP_EN
  logic [31:0] cycle_count;
  logic [31:0] frame_stamp;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cycle_count <= '0;
      frame_stamp <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (frame_start_i) frame_stamp <= cycle_count;
    end
  end

  assign push_entry         = {frame_stamp, frame_channel, word};
  assign sample_timestamp_o = sample_valid_o ? head[67:36] : '0;
`else
  assign push_entry = {frame_channel, word};
`endif

  // Storage carries no reset; outputs are gated by the occupancy count instead.
  always_ff @(posedge clock_i) begin
    if (write_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({write_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow_o <= 1'b1;
      else if (clear_overflow_i) overflow_o <= 1'b0;
    end
  end

  assign head             = mem[rd_ptr];
  assign sample_valid_o   = (count != '0);
  assign sample_data_o    = sample_valid_o ? head[31:0]  : '0;
  assign sample_channel_o = sample_valid_o ? head[35:32] : '0;
  assign fifo_count_o     = count;

endmodule

`default_nettype wire

// File: tb/tb_ads1256_sample_assembler.sv
// tb_ads1256_sample_assembler: directed vector table plus hand-written corner sequences.
// Covers the timestamp port when ADS1256_SAMPLE_TIMESTAMP_EN is defined.
`default_nettype none

module tb_ads1256_sample_assembler;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic [3:0]  channel_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        sample_valid_o;
  logic        sample_ready_i = 1'b0;
  logic [31:0] sample_data_o;
  logic [3:0]  sample_channel_o;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;
  logic        clear_overflow_i = 1'b0;
`ifdef ADS1256_SAMPLE_TIMESTAMP_EN
  logic [31:0] sample_timestamp_o;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  ads1256_sample_assembler #(.DEPTH(DEPTH)) dut (
    .clock_i          (clk),
    .reset_i          (reset_i),
    .frame_start_i    (frame_start_i),
    .channel_i        (channel_i),
    .byte_valid_i     (byte_valid_i),
    .byte_i           (byte_i),
    .sample_valid_o   (sample_valid_o),
    .sample_ready_i   (sample_ready_i),
    .sample_data_o    (sample_data_o),
    .sample_channel_o (sample_channel_o),
    .fifo_count_o     (fifo_count_o),
    .overflow_o       (overflow_o),
`ifdef ADS1256_SAMPLE_TIMESTAMP_EN
    .sample_timestamp_o (sample_timestamp_o),
`endif
    .clear_overflow_i (clear_overflow_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ch;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_i = 1'b0;
    frame_start_i = 1'b0;
    byte_valid_i = 1'b0;
    sample_ready_i = 1'b0;
    clear_overflow_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid_i = 1'b1;
    byte_i = b;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] ch, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic ready_last, input logic clear_last);
    frame_start_i = 1'b1;
    channel_i = ch;
    tick();
    frame_start_i = 1'b0;
    send_byte(b0);
    send_byte(b1);
    sample_ready_i = ready_last;
    clear_overflow_i = clear_last;
    send_byte(b2);
    sample_ready_i = 1'b0;
    clear_overflow_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ch: 4'h3, b0: 8'h12, b1: 8'h34, b2: 8'h56, exp: 32'h00123456};
    vecs[1] = '{ch: 4'h0, b0: 8'h80, b1: 8'h00, b2: 8'h01, exp: 32'hFF800001};
    vecs[2] = '{ch: 4'h7, b0: 8'h7F, b1: 8'hFF, b2: 8'hFF, exp: 32'h007FFFFF};
    vecs[3] = '{ch: 4'hF, b0: 8'h80, b1: 8'h00, b2: 8'h00, exp: 32'hFF800000};
    vecs[4] = '{ch: 4'h9, b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, exp: 32'hFFFFFFFF};
    vecs[5] = '{ch: 4'hC, b0: 8'h00, b1: 8'h00, b2: 8'h00, exp: 32'h00000000};

    apply_reset();
    check("reset_count", 32'(fifo_count_o), 32'd0);
    check("reset_valid", 32'(sample_valid_o), 32'd0);
    check("reset_overflow", 32'(overflow_o), 32'd0);
    check("reset_data", sample_data_o, 32'd0);
    check("reset_channel", 32'(sample_channel_o), 32'd0);

`ifdef ADS1256_SAMPLE_TIMESTAMP_EN
    // Counter is 0 right after release and advances once per edge.
    repeat (100) tick();
    send_frame(4'h2, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    check("ts_value", sample_timestamp_o, 32'd100);
    apply_reset();
`endif

    // Table of single frames: enqueue, hold, then pop.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].ch, vecs[i].b0, vecs[i].b1, vecs[i].b2, 1'b0, 1'b0);
      check("vec_valid", 32'(sample_valid_o), 32'd1);
      check("vec_data", sample_data_o, vecs[i].exp);
      check("vec_channel", 32'(sample_channel_o), 32'(vecs[i].ch));
      check("vec_count", 32'(fifo_count_o), 32'd1);
      tick();
      check("vec_hold_data", sample_data_o, vecs[i].exp);
      sample_ready_i = 1'b1;
      tick();
      sample_ready_i = 1'b0;
      check("vec_pop_count", 32'(fifo_count_o), 32'd0);
      check("vec_pop_valid", 32'(sample_valid_o), 32'd0);
    end

    // Abort mid-frame: partial sample is discarded without overflow.
    apply_reset();
    frame_start_i = 1'b1; channel_i = 4'h4; tick(); frame_start_i = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_frame(4'h6, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    check("abort_count", 32'(fifo_count_o), 32'd1);
    check("abort_data", sample_data_o, 32'h00010203);
    check("abort_channel", 32'(sample_channel_o), 32'h6);
    check("abort_overflow", 32'(overflow_o), 32'd0);

    // Frame start wins over a coincident byte strobe.
    apply_reset();
    frame_start_i = 1'b1; channel_i = 4'h5; tick();
    byte_valid_i = 1'b1; byte_i = 8'hEE; tick();
    frame_start_i = 1'b0; byte_valid_i = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("coinc_count", 32'(fifo_count_o), 32'd1);
    check("coinc_data", sample_data_o, 32'h00112233);
    check("coinc_channel", 32'(sample_channel_o), 32'h5);

    // Push and pop together at count 1: new sample becomes head.
    apply_reset();
    send_frame(4'h1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    send_frame(4'h2, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b0);
    check("pp1_count", 32'(fifo_count_o), 32'd1);
    check("pp1_data", sample_data_o, 32'h000A0B0C);
    check("pp1_channel", 32'(sample_channel_o), 32'h2);

    // Fill past capacity with no consumer.
    apply_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(4'(i), 8'(8'h10 + i), 8'h20, 8'(8'h30 + i), 1'b0, 1'b0);
    end
    check("full_count", 32'(fifo_count_o), 32'(DEPTH));
    check("full_overflow", 32'(overflow_o), 32'd1);
    check("full_head", sample_data_o, 32'h00102030);
    check("full_head_ch", 32'(sample_channel_o), 32'h0);
    clear_overflow_i = 1'b1; tick(); clear_overflow_i = 1'b0;
    check("clear_overflow", 32'(overflow_o), 32'd0);
    send_frame(4'hA, 8'h55, 8'h66, 8'h77, 1'b1, 1'b0);
    check("fullpp_count", 32'(fifo_count_o), 32'(DEPTH));
    check("fullpp_head", sample_data_o, 32'h00112031);
    check("fullpp_overflow", 32'(overflow_o), 32'd0);
    send_frame(4'hB, 8'h99, 8'h99, 8'h99, 1'b0, 1'b1);
    check("set_beats_clear", 32'(overflow_o), 32'd1);
    check("drop_count", 32'(fifo_count_o), 32'(DEPTH));
    sample_ready_i = 1'b1;
    repeat (DEPTH - 1) tick();
    sample_ready_i = 1'b0;
    check("drain_last_data", sample_data_o, 32'h00556677);
    check("drain_last_ch", 32'(sample_channel_o), 32'hA);
    sample_ready_i = 1'b1; tick(); sample_ready_i = 1'b0;
    check("drain_count", 32'(fifo_count_o), 32'd0);

    // Asynchronous reset in the middle of a frame with samples queued.
    apply_reset();
    for (int i = 0; i < 3; i++) send_frame(4'h8, 8'h01, 8'h00, 8'(i), 1'b0, 1'b0);
    check("prereset_count", 32'(fifo_count_o), 32'd3);
    frame_start_i = 1'b1; channel_i = 4'h8; tick(); frame_start_i = 1'b0;
    send_byte(8'h44);
    send_byte(8'h55);
    #2 reset_i = 1'b0;
    #1;
    check("areset_count", 32'(fifo_count_o), 32'd0);
    check("areset_valid", 32'(sample_valid_o), 32'd0);
    check("areset_data", sample_data_o, 32'd0);
    tick();
    reset_i = 1'b1;
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    check("postreset_ignore", 32'(fifo_count_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
